// File: rtl/mprjram_arbiter.sv
// Shares the single-port mprjram BRAM between the Wishbone CPU port and one accelerator master.
// The accelerator has priority, but a CPU access waits at most MAX_STREAK accelerator grants.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// C_IDLE   | no CPU access in flight; a Wishbone hit may be granted
// C_ISSUED | BRAM access issued last cycle; read data captured here
// C_ACK    | wbs_ack_o high for this one cycle
module mprjram_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int          ADDR_W     = 10,
    parameter int          MAX_STREAK = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              acc_en,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [31:0]       acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [31:0]       acc_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata
);

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_ISSUED = 2'd1,
        C_ACK    = 2'd2
    } cpu_state_t;

    localparam logic [3:0] STREAK_LOAD = 4'(MAX_STREAK);

    cpu_state_t  cpu_state;
    cpu_state_t  cpu_state_nxt;
    logic [3:0]  streak_left;
    logic [3:0]  streak_left_nxt;
    logic        cpu_we_q;
    logic        cpu_we_nxt;
    logic [31:0] wbs_dat_nxt;
    logic        cpu_hit;
    logic        cpu_pend;
    logic        acc_pend;
    logic        cpu_gnt;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        cpu_hit  = wbs_cyc_i & wbs_stb_i &
                   (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
        cpu_pend = (cpu_state == C_IDLE) & cpu_hit;
        acc_pend = acc_en & acc_req;
        // Streak budget is a down-counter: at zero the waiting CPU wins.
        cpu_gnt  = resetb & cpu_pend & (~acc_pend | (streak_left == 4'd0));
        acc_gnt  = resetb & acc_pend & ~cpu_gnt;
    end

    always_comb begin
        streak_left_nxt = streak_left;
        if (cpu_gnt || !cpu_pend) begin
            streak_left_nxt = STREAK_LOAD;
        end else if (acc_gnt && streak_left != 4'd0) begin
            streak_left_nxt = streak_left - 4'd1;
        end
    end

    always_comb begin
        cpu_state_nxt = cpu_state;
        cpu_we_nxt    = cpu_we_q;
        wbs_dat_nxt   = wbs_dat_o;
        case (cpu_state)
            C_IDLE: begin
                if (cpu_gnt) begin
                    cpu_state_nxt = C_ISSUED;
                    cpu_we_nxt    = wbs_we_i;
                end
            end
            C_ISSUED: begin
                cpu_state_nxt = C_ACK;
                if (!cpu_we_q) begin
                    wbs_dat_nxt = bram_rdata;
                end
            end
            C_ACK: begin
                cpu_state_nxt = C_IDLE;
            end
            default: begin
                cpu_state_nxt = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cpu_state   <= C_IDLE;
            streak_left <= STREAK_LOAD;
            cpu_we_q    <= 1'b0;
            wbs_dat_o   <= 32'h0;
            acc_rvalid  <= 1'b0;
        end else begin
            cpu_state   <= cpu_state_nxt;
            streak_left <= streak_left_nxt;
            cpu_we_q    <= cpu_we_nxt;
            wbs_dat_o   <= wbs_dat_nxt;
            acc_rvalid  <= acc_gnt & ~acc_we;
        end
    end

    assign wbs_ack_o = (cpu_state == C_ACK);
    assign acc_rdata = bram_rdata;

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 4'h0;
        bram_addr  = '0;
        bram_wdata = 32'h0;
        if (cpu_gnt) begin
            bram_en    = 1'b1;
            bram_we    = wbs_we_i ? wbs_sel_i : 4'h0;
            bram_addr  = wbs_adr_i[ADDR_W+1:2];
            bram_wdata = wbs_dat_i;
        end else if (acc_gnt) begin
            bram_en    = 1'b1;
            bram_we    = acc_we ? 4'hF : 4'h0;
            bram_addr  = acc_addr;
            bram_wdata = acc_wdata;
        end
    end

endmodule

// File: tb/tb_mprjram_arbiter.sv
// Directed bench for mprjram_arbiter with a behavioural BRAM that is read-first, one-cycle latency.
// Words not written by the bench hold 0xA000_0000 + word address.
module tb_mprjram_arbiter;

    logic        clock = 1'b0;
    logic        resetb;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        acc_en, acc_req, acc_we;
    logic [9:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_gnt, acc_rvalid;
    logic [31:0] acc_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    int checks = 0;
    int errors = 0;

    mprjram_arbiter #(
        .BASE_ADDR (32'h3800_0000),
        .ADDR_W    (10),
        .MAX_STREAK(4)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .acc_en    (acc_en),
        .acc_req   (acc_req),
        .acc_we    (acc_we),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .acc_gnt   (acc_gnt),
        .acc_rvalid(acc_rvalid),
        .acc_rdata (acc_rdata),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:1023];
    bit          mem_ready = 1'b0;

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem_ready <= 1'b1;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_rdata <= mem[bram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        hit;
        logic [9:0]  exp_addr;
        logic [31:0] exp_rdata;
    } cpu_vec_t;

    cpu_vec_t vecs[11];
    cpu_vec_t fresh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_idle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
    endtask

    // Called at a drive point with the accelerator idle; returns at a drive point.
    task automatic cpu_txn(input cpu_vec_t v);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = v.we;
        wbs_sel_i = v.sel;
        wbs_adr_i = v.adr;
        wbs_dat_i = v.dat;
        if (v.hit) begin
            @(negedge clock);
            chk("txn_grant_en", 32'(bram_en), 32'd1);
            chk("txn_grant_addr", 32'(bram_addr), 32'(v.exp_addr));
            chk("txn_grant_we", 32'(bram_we), 32'(v.we ? v.sel : 4'h0));
            if (v.we) chk("txn_grant_wdata", bram_wdata, v.dat);
            chk("txn_ack_t0", 32'(wbs_ack_o), 32'd0);
            next_cycle();
            @(negedge clock);
            chk("txn_ack_t1", 32'(wbs_ack_o), 32'd0);
            chk("txn_issued_no_en", 32'(bram_en), 32'd0);
            next_cycle();
            @(negedge clock);
            chk("txn_ack_t2", 32'(wbs_ack_o), 32'd1);
            if (!v.we) chk("txn_rdata", wbs_dat_o, v.exp_rdata);
            next_cycle();
        end else begin
            for (int c = 0; c < 50; c++) begin
                @(negedge clock);
                chk("miss_quiet", 32'({bram_en, wbs_ack_o}), 32'd0);
                next_cycle();
            end
        end
        cpu_idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 10'h004, 32'h0};
        vecs[1]  = '{1'b0, 32'h3800_0010, 4'hF, 32'h0,         1'b1, 10'h004, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h3800_0020, 4'hF, 32'h0000_0000, 1'b1, 10'h008, 32'h0};
        vecs[3]  = '{1'b1, 32'h3800_0020, 4'h3, 32'hFFFF_FFFF, 1'b1, 10'h008, 32'h0};
        vecs[4]  = '{1'b0, 32'h3800_0020, 4'hF, 32'h0,         1'b1, 10'h008, 32'h0000_FFFF};
        vecs[5]  = '{1'b1, 32'h3800_0FFC, 4'hF, 32'h1234_5678, 1'b1, 10'h3FF, 32'h0};
        vecs[6]  = '{1'b0, 32'h3800_0FFC, 4'hF, 32'h0,         1'b1, 10'h3FF, 32'h1234_5678};
        vecs[7]  = '{1'b1, 32'h3800_0010, 4'hC, 32'hAABB_CCDD, 1'b1, 10'h004, 32'h0};
        vecs[8]  = '{1'b0, 32'h3800_0010, 4'hF, 32'h0,         1'b1, 10'h004, 32'hAABB_BEEF};
        vecs[9]  = '{1'b0, 32'h3800_1000, 4'hF, 32'h0,         1'b0, 10'h000, 32'h0};
        vecs[10] = '{1'b1, 32'h37FF_FFFC, 4'hF, 32'h5555_5555, 1'b0, 10'h000, 32'h0};
        fresh    = '{1'b0, 32'h3800_0020, 4'hF, 32'h0,         1'b1, 10'h008, 32'h0000_FFFF};

        // Reset with both masters requesting: everything forced quiet.
        resetb    = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0010;
        wbs_dat_i = 32'h1111_1111;
        acc_en    = 1'b1;
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 10'd3;
        acc_wdata = 32'h2222_2222;
        @(negedge clock);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_rvalid", 32'(acc_rvalid), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_acc_gnt", 32'(acc_gnt), 32'd0);
        next_cycle();
        cpu_idle();
        acc_req = 1'b0;
        acc_we  = 1'b0;
        next_cycle();
        resetb = 1'b1;
        next_cycle();

        // 20 back-to-back accelerator reads, no CPU traffic.
        acc_en  = 1'b1;
        acc_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc_addr = 10'(i);
            @(negedge clock);
            chk("stream_gnt", 32'(acc_gnt), 32'd1);
            chk("stream_addr", 32'(bram_addr), 32'(i));
            chk("stream_we", 32'(bram_we), 32'd0);
            if (i > 0) begin
                chk("stream_rvalid", 32'(acc_rvalid), 32'd1);
                chk("stream_rdata", acc_rdata, 32'hA000_0000 + 32'(i - 1));
            end
            next_cycle();
        end
        acc_req = 1'b0;
        @(negedge clock);
        chk("stream_gnt_end", 32'(acc_gnt), 32'd0);
        chk("stream_rvalid_last", 32'(acc_rvalid), 32'd1);
        chk("stream_rdata_last", acc_rdata, 32'hA000_0013);
        next_cycle();
        @(negedge clock);
        chk("stream_rvalid_off", 32'(acc_rvalid), 32'd0);
        next_cycle();

        for (int v = 0; v < 11; v++) cpu_txn(vecs[v]);

        // CPU read arriving mid-stream: four accelerator grants, then the CPU.
        acc_req  = 1'b1;
        acc_addr = 10'd200;
        @(negedge clock);
        chk("cont_acc_pre", 32'(acc_gnt), 32'd1);
        next_cycle();
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("cont_acc_streak", 32'(acc_gnt), 32'd1);
            chk("cont_streak_addr", 32'(bram_addr), 32'd200);
            next_cycle();
        end
        @(negedge clock);
        chk("cont_cpu_wins", 32'(acc_gnt), 32'd0);
        chk("cont_cpu_en", 32'(bram_en), 32'd1);
        chk("cont_cpu_addr", 32'(bram_addr), 32'd4);
        next_cycle();
        @(negedge clock);
        chk("cont_acc_resume", 32'(acc_gnt), 32'd1);
        chk("cont_no_rvalid", 32'(acc_rvalid), 32'd0);
        chk("cont_ack_t1", 32'(wbs_ack_o), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("cont_ack_t2", 32'(wbs_ack_o), 32'd1);
        chk("cont_rdata", wbs_dat_o, 32'hAABB_BEEF);
        chk("cont_acc_during_ack", 32'(acc_gnt), 32'd1);
        next_cycle();
        cpu_idle();
        acc_req = 1'b0;
        next_cycle();

        // acc_en drops with acc_req still high: last read still returns.
        acc_req  = 1'b1;
        acc_addr = 10'd7;
        @(negedge clock);
        chk("en_fall_gnt", 32'(acc_gnt), 32'd1);
        next_cycle();
        acc_en = 1'b0;
        @(negedge clock);
        chk("en_fall_no_gnt", 32'(acc_gnt), 32'd0);
        chk("en_fall_no_en", 32'(bram_en), 32'd0);
        chk("en_fall_rvalid", 32'(acc_rvalid), 32'd1);
        chk("en_fall_rdata", acc_rdata, 32'hA000_0007);
        next_cycle();
        @(negedge clock);
        chk("en_fall_rvalid_off", 32'(acc_rvalid), 32'd0);
        next_cycle();
        acc_req = 1'b0;

        // Reset pulsed while the CPU access sits in C_ISSUED.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0020;
        @(negedge clock);
        chk("mid_rst_grant", 32'(bram_en), 32'd1);
        next_cycle();
        resetb  = 1'b0;
        acc_en  = 1'b1;
        acc_req = 1'b1;
        @(negedge clock);
        chk("mid_rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("mid_rst_en", 32'(bram_en), 32'd0);
        chk("mid_rst_acc_gnt", 32'(acc_gnt), 32'd0);
        chk("mid_rst_dat", wbs_dat_o, 32'h0);
        next_cycle();
        @(negedge clock);
        chk("mid_rst_ack_hold", 32'(wbs_ack_o), 32'd0);
        next_cycle();
        cpu_idle();
        acc_en  = 1'b0;
        acc_req = 1'b0;
        resetb  = 1'b1;
        @(negedge clock);
        chk("post_rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("post_rst_en", 32'(bram_en), 32'd0);
        next_cycle();
        cpu_txn(fresh);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mprjram_arbiter.md
# mprjram_arbiter

Arbiter sharing the single-port user-project BRAM (mprjram, Wishbone base 0x3800_0000) between the management-core Wishbone bus and one accelerator master (the FIR / matmul / qsort engine). Sits inside the user project between the Wishbone slave decode, the accelerator, and the BRAM macro. Grants one BRAM access per cycle. The accelerator has priority for throughput, and a bounded-streak rule guarantees CPU forward progress.

## Interface
- BASE_ADDR, 32'h3800_0000: byte base address of mprjram window.
- ADDR_W, 10: BRAM word-address width (4 KB).
- MAX_STREAK, 4: maximum consecutive accelerator grants while a CPU access waits (range 1..15).
- clock  in  1  system clock; all state on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- acc_en  in  1  accelerator port enable (LA-driven); when low, acc_req is ignored.
- acc_req, acc_we  in  1 each  accelerator request / write.
- acc_addr  in  ADDR_W  word address.
- acc_wdata  in  32  write data (always full word).
- acc_gnt  out  1  combinational: request accepted this cycle.
- acc_rvalid  out  1  read data valid.
- acc_rdata  out  32  read data (direct from bram_rdata; meaningful only with acc_rvalid).
- bram_en  out  1  BRAM access this cycle.
- bram_we  out  4  byte write enables.
- bram_addr  out  ADDR_W  word address.
- bram_wdata  out  32  write data.
- bram_rdata  in  32  read data, valid the cycle after bram_en with bram_we==0.

## Operation
- CPU hit: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]). CPU word address is wbs_adr_i[ADDR_W+1:2]. On a miss, no ack is generated; upstream decode owns misses.
- CPU FSM has three states.
  - C_IDLE: cpu_pend = hit. On CPU grant, go to C_ISSUED.
  - C_ISSUED: go to C_ACK unconditionally. Capture bram_rdata into wbs_dat_o if the access was a read.
  - C_ACK: wbs_ack_o=1 for exactly this cycle, then go to C_IDLE.
  - No new CPU grant is possible outside C_IDLE.
- acc_pend = acc_en & acc_req.
- Grant rule, evaluated each cycle:
  - Only one pending: it wins.
  - Both pending and streak < MAX_STREAK: accelerator wins and streak increments.
  - Both pending and streak == MAX_STREAK: CPU wins.
  - streak clears on any CPU grant, or on any cycle cpu_pend==0.
- BRAM drive (combinational from grant):
  - CPU grant: bram_we = wbs_we_i ? wbs_sel_i : 0, addr/wdata from Wishbone.
  - Acc grant: bram_we = acc_we ? 4'hF : 0, addr/wdata from acc port.
  - No grant: bram_en=0 and bram_we=0.
- acc_rvalid is registered: set the cycle after an accelerator read grant, otherwise 0. Back-to-back accelerator reads each return one rvalid, in order.
- Writes of either master return no data. The CPU write ack follows the same 3-state path.

## Timing
- Reset values:
  - CPU FSM = C_IDLE; streak = 0.
  - wbs_ack_o = 0; wbs_dat_o = 0; acc_rvalid = 0.
  - bram_en, bram_we, and acc_gnt are forced 0 while resetb is low.
- CPU latency: grant in cycle t, ack in t+2 with read data. Uncontended read/write: stb seen at t, ack at t+2. The CPU can issue at most once every 3 cycles.
- Accelerator: acc_gnt in t, rdata/acc_rvalid in t+1. Sustained 1 access/cycle when the CPU is idle.
- Worst-case CPU wait under a continuous accelerator stream: MAX_STREAK cycles, then grant.
- acc_en falling while acc_req is high: no further grants. A read granted the previous cycle still returns acc_rvalid.
- Reset asserted mid-transaction: the pending ack is dropped, no BRAM access is issued, and the CPU master must retry.
- Address at top of window (word 2^ADDR_W-1) is valid. The next byte address past the window is a miss.

## Test plan
- Idle accelerator; CPU writes 0xDEAD_BEEF to 0x3800_0010, then reads it back -> each ack arrives 2 cycles after grant; read returns 0xDEAD_BEEF; bram_addr=4.
- CPU writes with wbs_sel_i=4'b0011 over 0xFFFF_FFFF, after preloading 0x0000_0000 -> readback 0x0000_FFFF.
- acc_req held high for 20 reads at addresses 0..19 with acc_en=1, no CPU traffic -> 20 consecutive acc_gnt; each acc_rvalid one cycle later, in order.
- Continuous accelerator stream with a CPU read issued mid-stream, MAX_STREAK=4 -> exactly 4 accelerator grants, then CPU grant; ack 2 cycles later; the accelerator resumes the next cycle.
- CPU access to 0x3800_1000 (outside the 4 KB window) -> no bram_en, no ack for 50 cycles.
- resetb pulsed low in C_ISSUED -> wbs_ack_o stays 0, bram_en 0 during reset; after release, FSM is in C_IDLE and a fresh access completes normally.
